// File: rtl/code_pkg.sv
// Shared constants for the BIAS code emitter and its matching checker.
// Holds the FSM state type and the digit table, most-significant first.
package code_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BIAS_LEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } emit_state_t;

  // Entries past the BIAS code read as zero for longer sequences.
  function automatic logic [DIGIT_W-1:0] bias_digit(
    input int unsigned i
  );
    logic [DIGIT_W-1:0] d;
    case (i)
      0:       d = 4'd2;
      1:       d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/code_emit_gap_counter.sv
// Loadable down-counter that times the idle gap between digits.
// Stops at zero; zero flag is a decode of the count register.
module gap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/code_emit.sv
// Emits the BIAS code digits over a valid/ready link.
// Digits are separated by GAP_CYCLES idle cycles; DONE pulses at the end.
module code_emit
  import code_pkg::*;
#(
  parameter int GAP_CYCLES = 3,
  parameter int NUM_DIGITS = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         START,
  input  logic         READY,
  output logic [3:0]   DIGIT,
  output logic         VALID,
  output logic         BUSY,
  output logic         DONE
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NUM_DIGITS - 1);
  // Counter holds remaining gap cycles minus one.
  localparam logic [3:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  emit_state_t   state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic          gap_load, gap_en, gap_zero;

  logic [DIGIT_W-1:0] digit_q;
  logic               valid_q, busy_q, done_q;

  gap_counter #(.W(4)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (GAP_LOAD),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (READY) begin
          if (idx == LAST) begin
            state_d = ST_FIN;
          end else begin
            idx_d = idx + IW'(1);
            if (GAP_CYCLES == 0) begin
              state_d = ST_SEND;
            end else begin
              state_d  = ST_GAP;
              gap_load = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_d = ST_SEND;
        end else begin
          gap_en = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are flopped from the next-state view so
  // they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      valid_q <= 1'b0;
      digit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      valid_q <= (state_d == ST_SEND);
      digit_q <= (state_d == ST_SEND)
               ? bias_digit(32'(idx_d)) : '0;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FIN);
    end
  end

  assign DIGIT = digit_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_code_emit.sv
// Bench for code_emit: vector table, directed corners, random vs model.
// Two instances cover GAP_CYCLES=3 and GAP_CYCLES=0.
module tb_code_emit;
  import code_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, ready;
  logic [3:0] d3, d0;
  logic       v3, b3, dn3;
  logic       v0, b0, dn0;

  always #5 clk = ~clk;

  code_emit #(.GAP_CYCLES(3), .NUM_DIGITS(2)) u3 (
    .clk(clk), .reset(reset), .START(start), .READY(ready),
    .DIGIT(d3), .VALID(v3), .BUSY(b3), .DONE(dn3)
  );

  code_emit #(.GAP_CYCLES(0), .NUM_DIGITS(2)) u0 (
    .clk(clk), .reset(reset), .START(start), .READY(ready),
    .DIGIT(d0), .VALID(v0), .BUSY(b0), .DONE(dn0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a list of digits walked
  // by position, with a wait count standing in for the gap.
  int  tbl [2] = '{2, 9};
  int  mgap[2] = '{3, 0};
  bit  m_on;
  bit  m_act[2], m_fin[2];
  int  m_pos[2], m_wait[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_fin[k] = 0;
      m_pos[k] = 0; m_wait[k] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit r);
    for (int k = 0; k < 2; k++) begin
      if (m_fin[k]) begin
        m_fin[k] = 0;
        m_act[k] = 0;
      end else if (!m_act[k]) begin
        if (s) begin
          m_act[k] = 1; m_pos[k] = 0; m_wait[k] = 0;
        end
      end else if (m_wait[k] > 0) begin
        m_wait[k]--;
      end else if (r) begin
        if (m_pos[k] == 1) m_fin[k] = 1;
        else begin
          m_pos[k]++;
          m_wait[k] = mgap[k];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_on) model_step(start, ready);
    @(negedge clk);
  endtask

  task automatic model_cmp(input int k, input logic [3:0] d,
                           input logic v, input logic b,
                           input logic dn);
    bit ev;
    int ed;
    ev = m_act[k] && !m_fin[k] && (m_wait[k] == 0);
    ed = ev ? tbl[m_pos[k]] : 0;
    chk($sformatf("rnd%0d.valid", k), int'(v), int'(ev));
    chk($sformatf("rnd%0d.digit", k), int'(d), ed);
    chk($sformatf("rnd%0d.busy", k), int'(b), int'(m_act[k]));
    chk($sformatf("rnd%0d.done", k), int'(dn), int'(m_fin[k]));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       s;
    logic       r;
    logic       v;
    logic [3:0] d;
    logic       b;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic r, logic v,
                              logic [3:0] d, logic b,
                              logic dn);
    vec_t x;
    x.s = s; x.r = r; x.v = v; x.d = d; x.b = b; x.dn = dn;
    return x;
  endfunction

  logic [3:0] sw1, sw2;
  int         nxf, ndone;
  logic       chk_out;
  bit         seen;

  initial begin
    m_on  = 0;
    model_reset();
    start = 1'b0;
    ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.valid", int'(v3), 0);
    chk("rst.digit", int'(d3), 0);
    chk("rst.busy",  int'(b3), 0);
    chk("rst.done",  int'(dn3), 0);
    reset = 1'b0;
    tick();
    chk("idle.busy", int'(b3), 0);
    chk("idle.valid", int'(v3), 0);

    // GAP_CYCLES=3 trace; each row: inputs for the edge,
    // outputs expected after it.
    vecs.push_back(mk(1, 1, 1, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 9, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 1, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 9, 1, 0));
    vecs.push_back(mk(0, 0, 1, 9, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 9, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      start = vecs[i].s;
      ready = vecs[i].r;
      tick();
      chk($sformatf("vec%0d.valid", i), int'(v3), int'(vecs[i].v));
      chk($sformatf("vec%0d.digit", i), int'(d3), int'(vecs[i].d));
      chk($sformatf("vec%0d.busy", i), int'(b3), int'(vecs[i].b));
      chk($sformatf("vec%0d.done", i), int'(dn3), int'(vecs[i].dn));
    end

    // GAP_CYCLES=0: digits back to back.
    start = 1'b0;
    pulse_reset();
    start = 1'b1; ready = 1'b1;
    tick();
    chk("g0.v1", int'(v0), 1);
    chk("g0.d1", int'(d0), 2);
    start = 1'b0;
    tick();
    chk("g0.v2", int'(v0), 1);
    chk("g0.d2", int'(d0), 9);
    tick();
    chk("g0.done", int'(dn0), 1);
    chk("g0.fin_valid", int'(v0), 0);
    chk("g0.fin_busy", int'(b0), 1);
    tick();
    chk("g0.idle_busy", int'(b0), 0);
    chk("g0.idle_done", int'(dn0), 0);

    // Loopback into the code checker, START pulsed
    // throughout to confirm it is ignored mid-sequence.
    pulse_reset();
    sw1 = '0; sw2 = '0; nxf = 0; ndone = 0;
    start = 1'b1; ready = 1'b1;
    tick();
    for (int c = 0; c < 20 && ndone == 0; c++) begin
      start = c[0];
      ready = ($urandom_range(0, 1) == 1);
      if (v3 && ready) begin
        if (nxf == 0) sw2 = d3;
        else sw1 = d3;
        nxf++;
      end
      tick();
      if (dn3) ndone++;
    end
    start = 1'b0;
    chk("loop.done_seen", ndone, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dn3) ndone++;
    end
    chk("loop.xfers", nxf, 2);
    chk("loop.one_done", ndone, 1);
    chk_out = (sw2 == bias_digit(0)) && (sw1 == bias_digit(1));
    chk("loop.sw2", int'(sw2), 2);
    chk("loop.sw1", int'(sw1), 9);
    chk("loop.checker", int'(chk_out), 1);

    // Reset between edges while digit 9 is offered.
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (v3 && d3 == 4'd9) begin
        seen = 1;
      end else begin
        ready = 1'b1;
        tick();
      end
    end
    chk("mid.digit9_seen", int'(seen), 1);
    ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid.valid", int'(v3), 0);
    chk("mid.digit", int'(d3), 0);
    chk("mid.busy", int'(b3), 0);
    chk("mid.done", int'(dn3), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dn3 || b3) ndone++;
    end
    chk("mid.no_done", ndone, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid.restart_v", int'(v3), 1);
    chk("mid.restart_d", int'(d3), 2);

    // Random traffic against the model, both instances.
    pulse_reset();
    model_reset();
    m_on = 1;
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 1) == 1);
      tick();
      model_cmp(0, d3, v3, b3, dn3);
      model_cmp(1, d0, v0, b0, dn0);
    end
    m_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
